// File: rtl/data_memory.sv
// Byte-addressed big-endian data memory with sub-word access, alignment checks and
// req/ack handshake with LATENCY wait states. Define DATA_MEMORY_INIT_EN to preset word i = i.
module data_memory #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [31:0]          data_i,
    output logic                 ack_o,
    output logic [31:0]          data_o,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam int unsigned Depth   = 2 ** (ADDR_SIZE - 2);
    localparam bit          ZeroLat = (LATENCY == 0);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [31:0]            wdata_q;

    logic [31:0]            mem [Depth];

    logic                   accept;
    logic                   illegal;
    logic                   wait_done;
    logic                   access;
    logic                   direct;
    logic                   acc_we;
    logic [1:0]             acc_size;
    logic                   acc_uns;
    logic [ADDR_SIZE-1:0]   acc_addr;
    logic [31:0]            acc_data;
    logic [1:0]             acc_off;
    logic [ADDR_SIZE-3:0]   acc_idx;
    logic [3:0]             be;
    logic [31:0]            wlane;
    logic [31:0]            rd_word;
    logic [31:0]            rd_shift;
    logic [15:0]            rd_half;
    logic [31:0]            load_val;

`ifdef DATA_MEMORY_INIT_EN
    initial begin
        for (int i = 0; i < int'(Depth); i++) begin
            mem[i] = 32'(i);
        end
    end
`endif

    assign accept    = req_i && (state_q != StWait);
    assign illegal   = (size_i == 2'b11) || ((size_i == 2'b01) && addr_i[0]) ||
                       ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
    assign wait_done = (state_q == StWait) && (cnt_q == 4'd1);
    // Outside WAIT the only possible access is a zero-latency one straight from the inputs.
    assign direct    = (state_q != StWait);
    assign access    = rst_ni && (wait_done || (accept && !illegal && ZeroLat));

    assign acc_we   = direct ? we_i       : we_q;
    assign acc_size = direct ? size_i     : size_q;
    assign acc_uns  = direct ? unsigned_i : uns_q;
    assign acc_addr = direct ? addr_i     : addr_q;
    assign acc_data = direct ? data_i     : wdata_q;
    assign acc_off  = acc_addr[1:0];
    assign acc_idx  = acc_addr[ADDR_SIZE-1:2];

    // Offset 0 is the most significant byte lane.
    always_comb begin
        be    = 4'b1111;
        wlane = acc_data;
        unique case (acc_size)
            2'b00: begin
                be    = 4'b1000 >> acc_off;
                wlane = {4{acc_data[7:0]}};
            end
            2'b01: begin
                be    = acc_off[1] ? 4'b0011 : 4'b1100;
                wlane = {2{acc_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = acc_data;
            end
        endcase
    end

    assign rd_word  = mem[acc_idx];
    assign rd_shift = rd_word >> {~acc_off, 3'b000};
    assign rd_half  = acc_off[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        load_val = rd_word;
        unique case (acc_size)
            2'b00:   load_val = acc_uns ? {24'b0, rd_shift[7:0]} :
                                          {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = acc_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (access && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[acc_idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            data_o  <= 32'd0;
        end else begin
            if (access && !acc_we) begin
                data_o <= load_val;
            end
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                addr_q  <= addr_i;
                wdata_q <= data_i;
                cnt_q   <= 4'(LATENCY);
                if (illegal) begin
                    state_q <= StResp;
                    ack_o   <= 1'b1;
                    err_o   <= 1'b1;
                    busy_o  <= 1'b0;
                end else if (ZeroLat) begin
                    state_q <= StResp;
                    ack_o   <= 1'b1;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                end else begin
                    state_q <= StWait;
                    ack_o   <= 1'b0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StWait: begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= StResp;
                            ack_o   <= 1'b1;
                            busy_o  <= 1'b0;
                        end
                    end
                    StResp: begin
                        state_q <= StIdle;
                        ack_o   <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        ack_o   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: five instances with LATENCY 1, 3, 0, 2 and 4.
module tb_data_memory;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req   [5];
    logic        we    [5];
    logic        uns   [5];
    logic [1:0]  size  [5];
    logic [9:0]  addr  [5];
    logic [31:0] wdata [5];
    logic        ack   [5];
    logic        err   [5];
    logic        busy  [5];
    logic [31:0] rdata [5];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 :
                                      (g == 3) ? 2 : 4;
        data_memory #(
            .ADDR_SIZE (10),
            .LATENCY   (Lat)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .req_i      (req[g]),
            .we_i       (we[g]),
            .size_i     (size[g]),
            .unsigned_i (uns[g]),
            .addr_i     (addr[g]),
            .data_i     (wdata[g]),
            .ack_o      (ack[g]),
            .data_o     (rdata[g]),
            .err_o      (err[g]),
            .busy_o     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns edges from acceptance until ack is seen (bounded).
    task automatic do_access(input int n, input logic w, input logic [1:0] sz, input logic u,
                             input logic [9:0] a, input logic [31:0] d,
                             output int cyc, output logic [31:0] q, output logic e);
        req[n] = 1'b1; we[n] = w; size[n] = sz; uns[n] = u; addr[n] = a; wdata[n] = d;
        @(posedge clk); #1;
        req[n] = 1'b0;
        cyc = 1;
        while (ack[n] !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        q = rdata[n];
        e = err[n];
    endtask

    int          cyc;
    logic [31:0] q;
    logic        e;
    int          acks;
    int          busys;
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];

    initial begin
        for (int i = 0; i < 5; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; uns[i] = 1'b0; size[i] = 2'b00;
            addr[i] = '0; wdata[i] = '0;
        end
        exp_s = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F, 32'h00000001};
        exp_u = '{32'h00000080, 32'h000000FF, 32'h0000007F, 32'h00000001};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack[0], 0);
        check("rst_err", err[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_data", rdata[0], 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef DATA_MEMORY_INIT_EN
        do_access(4, 1'b0, 2'b10, 1'b0, 10'h100, 0, cyc, q, e);
        check("init_word64", q, 32'h00000040);
`endif

        // LATENCY=1 word load
        do_access(0, 1'b1, 2'b10, 1'b0, 10'h010, 32'h4, cyc, q, e);
        do_access(0, 1'b0, 2'b10, 1'b0, 10'h010, 0, cyc, q, e);
        check("lat1_cycles", cyc, 2);
        check("lat1_data", q, 32'h00000004);
        check("lat1_err", e, 0);

        // Reset mid-run, right in the RESP cycle
        rst_n = 1'b0;
        #1;
        check("midrst_ack", ack[0], 0);
        check("midrst_data", rdata[0], 0);
        check("midrst_err", err[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Byte loads, signed then unsigned
        do_access(0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h80FF7F01, cyc, q, e);
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1'b0, 2'b00, 1'b0, 10'(32'h20 + i), 0, cyc, q, e);
            check($sformatf("lb_s_off%0d", i), q, exp_s[i]);
        end
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1'b0, 2'b00, 1'b1, 10'(32'h20 + i), 0, cyc, q, e);
            check($sformatf("lb_u_off%0d", i), q, exp_u[i]);
        end

        // Sub-word stores merge into the word
        do_access(0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h11223344, cyc, q, e);
        do_access(0, 1'b1, 2'b01, 1'b0, 10'h022, 32'h0000BEEF, cyc, q, e);
        do_access(0, 1'b0, 2'b10, 1'b0, 10'h020, 0, cyc, q, e);
        check("sh_merge", q, 32'h1122BEEF);
        do_access(0, 1'b1, 2'b00, 1'b0, 10'h021, 32'h000000AA, cyc, q, e);
        do_access(0, 1'b0, 2'b10, 1'b0, 10'h020, 0, cyc, q, e);
        check("sb_merge", q, 32'h11AABEEF);
        do_access(0, 1'b0, 2'b01, 1'b0, 10'h020, 0, cyc, q, e);
        check("lh_s_off0", q, 32'h000011AA);
        do_access(0, 1'b0, 2'b01, 1'b0, 10'h022, 0, cyc, q, e);
        check("lh_s_off2", q, 32'hFFFFBEEF);
        do_access(0, 1'b0, 2'b01, 1'b1, 10'h022, 0, cyc, q, e);
        check("lh_u_off2", q, 32'h0000BEEF);

        // LATENCY=3 illegal accesses
        do_access(1, 1'b1, 2'b10, 1'b0, 10'h020, 32'h55667788, cyc, q, e);
        do_access(1, 1'b0, 2'b10, 1'b0, 10'h020, 0, cyc, q, e);
        check("lat3_cycles", cyc, 4);
        check("lat3_data", q, 32'h55667788);
        do_access(1, 1'b0, 2'b10, 1'b0, 10'h023, 0, cyc, q, e);
        check("mis_lw_cycles", cyc, 1);
        check("mis_lw_err", e, 1);
        check("mis_lw_data", q, 32'h55667788);
        do_access(1, 1'b1, 2'b10, 1'b0, 10'h023, 32'hFFFFFFFF, cyc, q, e);
        check("mis_sw_err", e, 1);
        do_access(1, 1'b1, 2'b11, 1'b0, 10'h020, 32'hFFFFFFFF, cyc, q, e);
        check("rsv_cycles", cyc, 1);
        check("rsv_err", e, 1);
        do_access(1, 1'b0, 2'b01, 1'b0, 10'h021, 0, cyc, q, e);
        check("mis_lh_err", e, 1);
        do_access(1, 1'b0, 2'b10, 1'b0, 10'h020, 0, cyc, q, e);
        check("no_write", q, 32'h55667788);
        check("err_clear", e, 0);

        // LATENCY=0, four back-to-back stores
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; addr[2] = 10'h000; wdata[2] = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat0_ack%0d", k), ack[2], 1);
            check($sformatf("lat0_busy%0d", k), busy[2], 0);
            if (k < 3) begin
                addr[2]  = 10'(4 * (k + 1));
                wdata[2] = 32'h100 + 32'(k + 1);
            end else begin
                req[2] = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("lat0_idle_ack", ack[2], 0);
        do_access(2, 1'b0, 2'b10, 1'b0, 10'h00C, 0, cyc, q, e);
        check("lat0_cycles", cyc, 1);
        check("lat0_data", q, 32'h00000103);

        // LATENCY=2 throughput with req held high
        req[3] = 1'b1; we[3] = 1'b1; size[3] = 2'b10; addr[3] = 10'h000; wdata[3] = 32'h5A;
        acks = 0;
        busys = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (ack[3] === 1'b1) acks++;
            if (busy[3] === 1'b1) busys++;
        end
        req[3] = 1'b0;
        check("lat2_acks", acks, 3);
        check("lat2_busy", busys, 6);
        @(posedge clk); #1;

        // LATENCY=4 store aborted by reset in WAIT
        do_access(4, 1'b1, 2'b10, 1'b0, 10'h040, 32'h00000010, cyc, q, e);
        req[4] = 1'b1; we[4] = 1'b1; size[4] = 2'b10; addr[4] = 10'h040;
        wdata[4] = 32'hDEADBEEF;
        @(posedge clk); #1;
        req[4] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ack", ack[4], 0);
        check("abort_busy", busy[4], 0);
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack[4] === 1'b1) acks++;
        end
        check("abort_noack", acks, 0);
        rst_n = 1'b1;
        do_access(4, 1'b0, 2'b10, 1'b0, 10'h040, 0, cyc, q, e);
        check("abort_cycles", cyc, 5);
        check("abort_data", q, 32'h00000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised data memory for the MIPS datapath, successor to the single-word register-file style RAM. It provides byte-addressed, big-endian storage with byte/halfword/word loads and stores, sign or zero extension on sub-word loads, and alignment checking. A req/ack handshake with a programmable number of wait states lets the core be exercised against slow memory. It sits between the memory pipeline stage and the storage array.

## Interface

- ADDR_SIZE, 10, byte-address width; array holds 2**(ADDR_SIZE-2) 32-bit words
- LATENCY, 1, wait states between acceptance and array access, 0..15

- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- req_i  input  1  request valid; accepted on a rising edge when busy_o is low
- we_i  input  1  1 = store, 0 = load
- size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- unsigned_i  input  1  load only: 1 = zero-extend, 0 = sign-extend
- addr_i  input  ADDR_SIZE  byte address
- data_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- ack_o  output  1  one-cycle response strobe
- data_o  output  32  load result, extended to 32 bits
- err_o  output  1  valid with ack_o: misaligned or reserved-size access
- busy_o  output  1  request in flight; req_i ignored while high

## Operation

- States: IDLE, WAIT, RESP.
- IDLE or RESP with req_i high: capture we/size/unsigned/addr/data; load counter with LATENCY.
  - If the request is illegal, go to RESP with err_o=1. No array access occurs.
  - If it is legal and LATENCY=0, access the array on this edge and go to RESP.
  - If it is legal and LATENCY>0, go to WAIT.
- WAIT: decrement the counter each edge. When the counter is 1, access the array on that edge and go to RESP.
- RESP: ack_o=1 for this one cycle. With req_i high, go back through acceptance as above; otherwise go to IDLE.
- Illegal request: size_i=11, halfword with addr[0]=1, or word with addr[1:0]≠00.
- Byte lanes, big-endian: offset 0 is word bits [31:24] and offset 3 is [7:0]. Halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Store: only the addressed byte lanes are written; all other lanes are preserved.
- Load: select the addressed lanes, shift them right-justified, then extend per unsigned_i. The word is read at the access edge and registered into data_o.
- data_o is updated only on a legal load's ack. It holds its value through stores, errors and idle time.
- err_o is registered with ack_o and cleared at the next accepted request or reset.
- The array is not cleared by reset.

## Timing

- Reset values: ack_o=0, err_o=0, busy_o=0, data_o=0, state IDLE, counter 0.
- Acceptance at edge E0. Array access at E0+LATENCY, or at E0 itself when LATENCY=0. ack_o is high during the cycle after edge E0+LATENCY.
- An illegal request acks in the cycle after E0, regardless of LATENCY.
- busy_o is high from after E0 until the RESP cycle, and low during RESP.
- Back-to-back: a request presented during RESP is accepted at the edge that ends RESP.
- Peak throughput is one access per LATENCY+1 cycles.
- A load immediately following a store to the same word returns the merged new data.
- Reset asserted in WAIT: return to IDLE immediately. The pending store is discarded, the array is unchanged, and no ack is produced.
- Reset is released synchronously to clk_i by the system; the block requires no reset synchronizer.

## Configuration

- DATA_MEMORY_INIT_EN defined: at time zero, word i is initialised to value i, for simulation-visible known contents.
- DATA_MEMORY_INIT_EN undefined: no initial block; contents are X until written, and the array infers as plain block RAM.
- The macro has no effect on ports, timing or reset behaviour.

## Test plan

- Reset, LATENCY=1, DATA_MEMORY_INIT_EN: drop rst_ni mid-run → all outputs 0. Load word at addr 0x010 → ack_o exactly 2 cycles after acceptance, data_o=0x00000004, err_o=0.
- Store word 0x80FF7F01 at 0x020, then load bytes signed at offsets 0..3 → 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001. Repeat unsigned → 0x00000080, 0x000000FF, 0x0000007F, 0x00000001.
- Store halfword 0xBEEF at 0x022 over word 0x11223344 → load word returns 0x1122BEEF. Store byte 0xAA at 0x021 → 0x11AABEEF.
- Load word at 0x023 with LATENCY=3 → ack_o in the cycle after acceptance with err_o=1, data_o unchanged. size_i=11 gives the same result. Subsequent load of that word shows no write occurred.
- LATENCY=0, req_i held high for 4 requests → ack_o high every cycle after the first, busy_o never high. LATENCY=2 → one ack every 3 cycles.
- LATENCY=4: store 0xDEADBEEF to 0x040 and assert rst_ni low 2 cycles after acceptance → no ack. Load 0x040 after reset returns the prior contents (0x00000010 with init).
